axi_s_fifo: RTL and testbench

- Parametrised AXI-Stream FIFO: AXI-Stream slave port in, AXI-Stream master port out, with tlast carried alongside data.
- Sits between an axi_s_m-style source and an axi_s_s-style sink.
- Generalises the fixed 8-bit, unbuffered master/slave link to configurable width and depth, adds backpressure buffering, fill-level and packet-count status, and an optional store-and-forward mode.

---
 rtl/axi_s_fifo.sv | 131 +++++++++++++
 tb/tb_axi_s_fifo.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_s_fifo.sv
// rtl/axi_s_fifo.sv - parametrised AXI-Stream FIFO with tlast, fill level and packet count
//
// Buffers beats from an AXI-Stream slave port to an AXI-Stream master port.
// Each entry holds {tlast, tdata}. Read side is first-word-fall-through.
//
// Optional build macro: AXI_S_FIFO_PKT_MODE_EN
//   defined   : store-and-forward; m_tvalid = !empty & ((pkt_count != 0) | full)
//   undefined : plain FIFO;        m_tvalid = !empty
//
// Parameters:
//   DATA_W  tdata width (>= 1)
//   DEPTH   storage entries, power of two, >= 2
//   ADDR_W  derived pointer index width
//
// Ports:
//   clk        rising-edge clock
//   areset     asynchronous active-low reset
//   s_tvalid   upstream beat valid
//   s_tready   FIFO can accept a beat (= !full)
//   s_tdata    upstream data
//   s_tlast    upstream end-of-packet
//   m_tvalid   beat available downstream
//   m_tready   downstream accepts beat
//   m_tdata    downstream data (0 when empty)
//   m_tlast    downstream end-of-packet (0 when empty)
//   count      entries stored, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   pkt_count  tlast beats currently stored

`timescale 1ns/1ps

module axi_s_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   pkt_count
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    // Pointers carry one extra MSB so that full and empty are distinguishable
    // when the index bits are equal.
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   pkt_cnt;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;

    logic [DATA_W:0]   mem [DEPTH];
    logic [DATA_W:0]   rd_entry;

    logic              push;
    logic              pop;
    logic              push_last;
    logic              pop_last;

    assign wr_idx = wr_ptr[ADDR_W-1:0];
    assign rd_idx = rd_ptr[ADDR_W-1:0];

    // Status is derived only from registered pointers, so there is no
    // combinational path from any input to count/full/empty/s_tready.
    assign full      = (wr_idx == rd_idx) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign empty     = (wr_ptr == rd_ptr);
    assign count     = wr_ptr - rd_ptr;
    assign pkt_count = pkt_cnt;

    // Acceptance is blocked whenever full, even if a pop happens the same
    // cycle; this keeps s_tready free of any dependence on m_tready.
    assign s_tready = !full;

`ifdef AXI_S_FIFO_PKT_MODE_EN
    // Hold beats back until a complete packet is stored. The full term lets
    // packets longer than DEPTH trickle out so the FIFO cannot deadlock.
    assign m_tvalid = !empty && ((pkt_cnt != '0) || full);
`else
    assign m_tvalid = !empty;
`endif

    assign rd_entry = mem[rd_idx];
    assign m_tdata  = empty ? '0   : rd_entry[DATA_W-1:0];
    assign m_tlast  = empty ? 1'b0 : rd_entry[DATA_W];

    assign push      = s_tvalid && s_tready;
    assign pop       = m_tvalid && m_tready;
    assign push_last = push && s_tlast;
    assign pop_last  = pop && m_tlast;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pkt_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_last, pop_last})
                2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
                2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // Storage array is deliberately not reset; stale entries are never
    // visible because the read mux is gated by empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= {s_tlast, s_tdata};
        end
    end

endmodule

// File: tb/tb_axi_s_fifo.sv
// tb/tb_axi_s_fifo.sv - self-checking bench for axi_s_fifo with a queue reference model

`timescale 1ns/1ps

module tb_axi_s_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CW     = 3;

    logic              clk = 1'b0;
    logic              areset = 1'b0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [DATA_W-1:0] s_tdata = '0;
    logic              s_tlast = 1'b0;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tlast;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic [CW-1:0]     pkt_count;

    axi_s_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .areset    (areset),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .s_tlast   (s_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: an ordered queue of {tlast, tdata} beats.
    logic [DATA_W:0]   q[$];
    logic [CW-1:0]     exp_count;
    logic [CW-1:0]     exp_pkt;
    logic              exp_full;
    logic              exp_empty;
    logic              exp_s_tready;
    logic              exp_m_tvalid;
    logic [DATA_W-1:0] exp_m_tdata;
    logic              exp_m_tlast;
    logic              exp_push;
    logic              exp_pop;

    function automatic logic [CW-1:0] model_pkts();
        int n = 0;
        foreach (q[i]) if (q[i][DATA_W]) n++;
        return CW'(n);
    endfunction

    // Apply inputs in the low phase and derive what the FIFO must show now.
    task automatic drive(input logic sv, input logic [DATA_W-1:0] sd, input logic sl, input logic mr);
        s_tvalid = sv;
        s_tdata  = sd;
        s_tlast  = sl;
        m_tready = mr;
        #1;
        exp_count    = CW'(q.size());
        exp_full     = (q.size() == DEPTH);
        exp_empty    = (q.size() == 0);
        exp_s_tready = !exp_full;
        exp_pkt      = model_pkts();
`ifdef AXI_S_FIFO_PKT_MODE_EN
        exp_m_tvalid = !exp_empty && ((exp_pkt != 0) || exp_full);
`else
        exp_m_tvalid = !exp_empty;
`endif
        if (exp_empty) begin
            exp_m_tdata = '0;
            exp_m_tlast = 1'b0;
        end else begin
            exp_m_tdata = q[0][DATA_W-1:0];
            exp_m_tlast = q[0][DATA_W];
        end
        exp_push = sv && exp_s_tready;
        exp_pop  = exp_m_tvalid && mr;
    endtask

    task automatic advance();
        @(posedge clk);
        if (exp_pop) void'(q.pop_front());
        if (exp_push) q.push_back({s_tlast, s_tdata});
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        areset   = 1'b0;
        q.delete();
        @(negedge clk);
        areset = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        if (s_tready !== 1'b1) begin failures++; $display("FAIL rst_s_tready got=%0b exp=1", s_tready); end checks++;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rst_m_tvalid got=%0b exp=0", m_tvalid); end checks++;
        if (full !== 1'b0) begin failures++; $display("FAIL rst_full got=%0b exp=0", full); end checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%0b exp=1", empty); end checks++;
        if (m_tdata !== 8'h00) begin failures++; $display("FAIL rst_m_tdata got=%0h exp=0", m_tdata); end checks++;
        if (m_tlast !== 1'b0) begin failures++; $display("FAIL rst_m_tlast got=%0b exp=0", m_tlast); end checks++;
        if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end checks++;
        if (pkt_count !== 3'd0) begin failures++; $display("FAIL rst_pkt_count got=%0d exp=0", pkt_count); end checks++;
        @(negedge clk);
        areset = 1'b1;
        // Three beats in flight, one of them a packet end, then reset between edges.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h30 + i), (i == 1), 1'b0);
            advance();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        if (count !== 3'd3) begin failures++; $display("FAIL rst_pre_count got=%0d exp=3", count); end checks++;
        if (pkt_count !== 3'd1) begin failures++; $display("FAIL rst_pre_pkt got=%0d exp=1", pkt_count); end checks++;
        #1;
        areset = 1'b0;
        #1;
        if (count !== 3'd0) begin failures++; $display("FAIL rst_async_count got=%0d exp=0", count); end checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL rst_async_empty got=%0b exp=1", empty); end checks++;
        if (s_tready !== 1'b1) begin failures++; $display("FAIL rst_async_s_tready got=%0b exp=1", s_tready); end checks++;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rst_async_m_tvalid got=%0b exp=0", m_tvalid); end checks++;
        if (pkt_count !== 3'd0) begin failures++; $display("FAIL rst_async_pkt got=%0d exp=0", pkt_count); end checks++;
        q.delete();
        @(negedge clk);
        areset = 1'b1;
        drive(1'b1, 8'h5A, 1'b1, 1'b0);
        advance();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        if (count !== 3'd1) begin failures++; $display("FAIL rst_post_count got=%0d exp=1", count); end checks++;
        if (pkt_count !== 3'd1) begin failures++; $display("FAIL rst_post_pkt got=%0d exp=1", pkt_count); end checks++;
        if (m_tdata !== 8'h5A) begin failures++; $display("FAIL rst_post_data got=%0h exp=5a", m_tdata); end checks++;
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'((i + 1) * 17), (i == 3), 1'b0);
            if (s_tready !== 1'b1) begin failures++; $display("FAIL fd_accept%0d got=%0b exp=1", i, s_tready); end checks++;
            advance();
        end
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        if (full !== 1'b1) begin failures++; $display("FAIL fd_full got=%0b exp=1", full); end checks++;
        if (s_tready !== 1'b0) begin failures++; $display("FAIL fd_s_tready got=%0b exp=0", s_tready); end checks++;
        if (count !== 3'd4) begin failures++; $display("FAIL fd_count got=%0d exp=4", count); end checks++;
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1);
            if (m_tvalid !== 1'b1) begin failures++; $display("FAIL fd_valid%0d got=%0b exp=1", i, m_tvalid); end checks++;
            if (m_tdata !== 8'((i + 1) * 17)) begin failures++; $display("FAIL fd_data%0d got=%0h exp=%0h", i, m_tdata, 8'((i + 1) * 17)); end checks++;
            advance();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        if (empty !== 1'b1) begin failures++; $display("FAIL fd_empty got=%0b exp=1", empty); end checks++;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL fd_end_valid got=%0b exp=0", m_tvalid); end checks++;
    endtask

    task automatic test_streaming();
        logic ev;
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            drive((i < 16), 8'(i), 1'b1, 1'b1);
            ev = (i > 0);
            if (m_tvalid !== ev) begin failures++; $display("FAIL st_valid%0d got=%0b exp=%0b", i, m_tvalid, ev); end checks++;
            if (i > 0) begin
                if (m_tdata !== 8'(i - 1)) begin failures++; $display("FAIL st_data%0d got=%0h exp=%0h", i, m_tdata, 8'(i - 1)); end checks++;
                if (count !== 3'd1) begin failures++; $display("FAIL st_count%0d got=%0d exp=1", i, count); end checks++;
            end
            advance();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        if (empty !== 1'b1) begin failures++; $display("FAIL st_empty got=%0b exp=1", empty); end checks++;
    endtask

    task automatic test_tlast();
        logic [7:0] dat [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
        logic       lst [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, dat[i], lst[i], 1'b0);
            advance();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        if (pkt_count !== 3'd2) begin failures++; $display("FAIL tl_pkt2 got=%0d exp=2", pkt_count); end checks++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1);
            if (m_tvalid !== 1'b1) begin failures++; $display("FAIL tl_valid%0d got=%0b exp=1", i, m_tvalid); end checks++;
            if (m_tdata !== dat[i]) begin failures++; $display("FAIL tl_data%0d got=%0h exp=%0h", i, m_tdata, dat[i]); end checks++;
            if (m_tlast !== lst[i]) begin failures++; $display("FAIL tl_last%0d got=%0b exp=%0b", i, m_tlast, lst[i]); end checks++;
            advance();
            if (i == 2) begin
                drive(1'b0, 8'h00, 1'b0, 1'b0);
                if (pkt_count !== 3'd1) begin failures++; $display("FAIL tl_pkt1 got=%0d exp=1", pkt_count); end checks++;
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        if (pkt_count !== 3'd0) begin failures++; $display("FAIL tl_pkt0 got=%0d exp=0", pkt_count); end checks++;
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
            advance();
        end
        drive(1'b1, 8'h99, 1'b0, 1'b1);
        if (full !== 1'b1) begin failures++; $display("FAIL fp_full got=%0b exp=1", full); end checks++;
        if (s_tready !== 1'b0) begin failures++; $display("FAIL fp_s_tready got=%0b exp=0", s_tready); end checks++;
        if (m_tvalid !== 1'b1) begin failures++; $display("FAIL fp_m_tvalid got=%0b exp=1", m_tvalid); end checks++;
        advance();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        if (count !== 3'd3) begin failures++; $display("FAIL fp_count got=%0d exp=3", count); end checks++;
        if (full !== 1'b0) begin failures++; $display("FAIL fp_not_full got=%0b exp=0", full); end checks++;
        if (m_tdata !== 8'hC1) begin failures++; $display("FAIL fp_next_data got=%0h exp=c1", m_tdata); end checks++;
        if (pkt_count !== 3'd3) begin failures++; $display("FAIL fp_pkt got=%0d exp=3", pkt_count); end checks++;
    endtask

    task automatic test_random();
        int sv_bias;
        int mr_bias;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            // Shift the producer/consumer balance every 100 beats to visit full and empty.
            sv_bias = ((n / 100) % 3) + 1;
            mr_bias = 3 - ((n / 100) % 3);
            drive(($urandom_range(0, 3) < sv_bias), 8'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) < mr_bias));
            if (s_tready !== exp_s_tready) begin failures++; $display("FAIL rnd_s_tready n=%0d got=%0b exp=%0b", n, s_tready, exp_s_tready); end checks++;
            if (m_tvalid !== exp_m_tvalid) begin failures++; $display("FAIL rnd_m_tvalid n=%0d got=%0b exp=%0b", n, m_tvalid, exp_m_tvalid); end checks++;
            if (m_tdata !== exp_m_tdata) begin failures++; $display("FAIL rnd_m_tdata n=%0d got=%0h exp=%0h", n, m_tdata, exp_m_tdata); end checks++;
            if (m_tlast !== exp_m_tlast) begin failures++; $display("FAIL rnd_m_tlast n=%0d got=%0b exp=%0b", n, m_tlast, exp_m_tlast); end checks++;
            if (count !== exp_count) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, exp_count); end checks++;
            if (full !== exp_full) begin failures++; $display("FAIL rnd_full n=%0d got=%0b exp=%0b", n, full, exp_full); end checks++;
            if (empty !== exp_empty) begin failures++; $display("FAIL rnd_empty n=%0d got=%0b exp=%0b", n, empty, exp_empty); end checks++;
            if (pkt_count !== exp_pkt) begin failures++; $display("FAIL rnd_pkt n=%0d got=%0d exp=%0d", n, pkt_count, exp_pkt); end checks++;
            advance();
        end
    endtask

`ifdef AXI_S_FIFO_PKT_MODE_EN
    task automatic test_pkt_mode();
        int sent;
        int rcv;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'hA0 + i), (i == 2), 1'b1);
            if (m_tvalid !== 1'b0) begin failures++; $display("FAIL pm_hold%0d got=%0b exp=0", i, m_tvalid); end checks++;
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1);
            if (m_tvalid !== 1'b1) begin failures++; $display("FAIL pm_rel%0d got=%0b exp=1", i, m_tvalid); end checks++;
            if (m_tdata !== 8'(8'hA0 + i)) begin failures++; $display("FAIL pm_data%0d got=%0h exp=%0h", i, m_tdata, 8'(8'hA0 + i)); end checks++;
            advance();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL pm_drop got=%0b exp=0", m_tvalid); end checks++;
        // A packet longer than DEPTH must still make progress through the full override.
        do_reset();
        sent = 0;
        rcv = 0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            drive((sent < 6), 8'(8'h60 + sent), (sent == 5), 1'b1);
            if (m_tvalid !== exp_m_tvalid) begin failures++; $display("FAIL pm6_valid c=%0d got=%0b exp=%0b", cyc, m_tvalid, exp_m_tvalid); end checks++;
            if (m_tvalid && rcv == 0) begin
                if (full !== 1'b1) begin failures++; $display("FAIL pm6_first_full got=%0b exp=1", full); end checks++;
            end
            if (m_tvalid) begin
                if (m_tdata !== 8'(8'h60 + rcv)) begin failures++; $display("FAIL pm6_data%0d got=%0h exp=%0h", rcv, m_tdata, 8'(8'h60 + rcv)); end checks++;
                rcv++;
            end
            if (exp_push) sent++;
            advance();
        end
        if (rcv !== 6) begin failures++; $display("FAIL pm6_drained got=%0d exp=6", rcv); end checks++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_streaming();
        test_tlast();
        test_full_pop();
`ifdef AXI_S_FIFO_PKT_MODE_EN
        test_pkt_mode();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
